// File: rtl/clk_util_pkg.sv
// Shared clocking-utility definitions: meter FSM encoding and default constants.
package clk_util_pkg;

  localparam int unsigned SYS_CLK_HZ = 50_000_000;
  localparam int unsigned CNT_W      = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } meter_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input plus a one-cycle rising-edge pulse.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic rise_c
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = d_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  // s3 is history only; it never feeds logic other than the edge compare
  assign rise_c = s2_q & ~s3_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the clk-cycle period of a slow asynchronous clock, flagging tolerance,
// lock and stall (timeout) conditions.
module clk_period_meter #(
  parameter int unsigned CNT_W          = clk_util_pkg::CNT_W,
  parameter int unsigned EXP_CYCLES     = 50_000_000,
  parameter int unsigned TOL            = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned LOCK_COUNT     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             in_tol,
  output logic             locked,
  output logic             timeout
);

  import clk_util_pkg::*;

  localparam int unsigned DW    = CNT_W + 1;
  localparam int unsigned LCK_W = $clog2(LOCK_COUNT + 1);

  logic sig_rise_c;

  meter_state_e     state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [CNT_W-1:0] period_q,   period_d;
  logic             valid_q,    valid_d;
  logic             in_tol_q,   in_tol_d;
  logic             locked_q,   locked_d;
  logic             timeout_q,  timeout_d;
  logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;

  logic signed [DW-1:0] diff_c;
  logic [DW-1:0]        mag_c;
  logic                 tol_ok_c;
  logic [LCK_W-1:0]     lock_inc_c;

  sync_edge_det u_sync (
    .clk    (clk),
    .rst_n  (rst),
    .d_in   (sig_in),
    .rise_c (sig_rise_c)
  );

  // Signed one-bit-wider difference so periods far below EXP_CYCLES cannot alias
  always_comb begin
    diff_c     = $signed({1'b0, cnt_q}) - $signed({1'b0, CNT_W'(EXP_CYCLES)});
    mag_c      = diff_c[DW-1] ? $unsigned(-diff_c) : $unsigned(diff_c);
    tol_ok_c   = (mag_c <= DW'(TOL));
    lock_inc_c = (lock_cnt_q == LCK_W'(LOCK_COUNT)) ? lock_cnt_q
                                                    : lock_cnt_q + LCK_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    in_tol_d   = in_tol_q;
    locked_d   = locked_q;
    timeout_d  = timeout_q;
    lock_cnt_d = lock_cnt_q;

    if (sig_rise_c)    cnt_d = CNT_W'(1);
    else if (&cnt_q)   cnt_d = cnt_q;
    else               cnt_d = cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (sig_rise_c) state_d = MEASURE;
      end
      MEASURE: begin
        // An edge on the timeout cycle still completes a valid period
        if (sig_rise_c) begin
          period_d = cnt_q;
          valid_d  = 1'b1;
          in_tol_d = tol_ok_c;
          if (tol_ok_c) begin
            lock_cnt_d = lock_inc_c;
            locked_d   = (lock_inc_c == LCK_W'(LOCK_COUNT));
          end else begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d    = TIMEOUT;
          timeout_d  = 1'b1;
          locked_d   = 1'b0;
          lock_cnt_d = '0;
          in_tol_d   = 1'b0;
        end
      end
      TIMEOUT: begin
        // Recovery edge only re-arms; the stalled interval is not a period
        if (sig_rise_c) begin
          state_d   = MEASURE;
          timeout_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      in_tol_q   <= 1'b0;
      locked_q   <= 1'b0;
      timeout_q  <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      in_tol_q   <= in_tol_d;
      locked_q   <= locked_d;
      timeout_q  <= timeout_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign in_tol       = in_tol_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule
